// File: rtl/regfile_pkg.sv
// regfile_pkg: shared state encoding, default sizes and packed-port slicing for regfile_mp
package regfile_pkg;
  localparam logic ST_CLEAR = 1'b0;
  localparam logic ST_READY = 1'b1;
  localparam int DATA_W_DEF = 32;
  localparam int DEPTH_DEF = 32;
  localparam int NUM_RD_DEF = 2;
  function automatic int slice_lo(input int p, input int w);
    return p * w;
  endfunction
endpackage

// File: rtl/regfile_clear_seq.sv
// regfile_clear_seq: CLEAR/READY state, clear index sweep and ready flag
module regfile_clear_seq import regfile_pkg::*; #(
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr_req_i,
  output logic                     ready_o,
  output logic                     clr_we_o,
  output logic [$clog2(DEPTH)-1:0] clr_addr_o
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);
  logic          st_q;
  logic [AW-1:0] idx_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      st_q  <= ST_CLEAR;
      idx_q <= '0;
    end else if (st_q == ST_CLEAR) begin
      idx_q <= idx_q + 1'b1;
      if (idx_q == LAST) st_q <= ST_READY;
    end else if (clr_req_i) begin
      st_q  <= ST_CLEAR;
      idx_q <= '0;
    end
  end
  assign ready_o    = st_q == ST_READY;
  assign clr_we_o   = st_q == ST_CLEAR;
  assign clr_addr_o = idx_q;
endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: multi-read-port register file with byte-enabled writes, bypass,
// optional hardwired r0 and a sequenced clear sweep
module regfile_mp import regfile_pkg::*; #(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int DEPTH    = DEPTH_DEF,
  parameter int ADDR_W   = $clog2(DEPTH),
  parameter int NUM_RD   = NUM_RD_DEF,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr_req,
  output logic                     ready,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W/8-1:0]      wr_be,
  input  logic [DATA_W-1:0]        wr_data,
  output logic [DEPTH*DATA_W-1:0]  reg_out
);
  localparam int NB = DATA_W / 8;
  localparam bit ZR = ZERO_REG != 0;
  localparam bit BP = BYPASS != 0;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] wr_old, wr_merged;
  logic              clr_we, wr_ok;
  logic [ADDR_W-1:0] clr_addr;
  regfile_clear_seq #(.DEPTH(DEPTH)) u_seq (
    .clk        (clk),
    .rst        (rst),
    .clr_req_i  (clr_req),
    .ready_o    (ready),
    .clr_we_o   (clr_we),
    .clr_addr_o (clr_addr)
  );
  // writes land only in READY and never on r0 when it is hardwired
  assign wr_ok  = ready & wr_en & ~rst & ~(ZR & (wr_addr == '0));
  assign wr_old = mem_q[wr_addr];
  for (genvar b = 0; b < NB; b++) begin : g_be
    assign wr_merged[8*b +: 8] = wr_be[b] ? wr_data[8*b +: 8] : wr_old[8*b +: 8];
  end
  always_ff @(posedge clk) begin
    if (clr_we) mem_q[clr_addr] <= '0;
    else if (wr_ok) mem_q[wr_addr] <= wr_merged;
  end
  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic              hit, zero;
    assign ra   = rd_addr[slice_lo(p, ADDR_W) +: ADDR_W];
    assign hit  = BP & wr_ok & (ra == wr_addr);
    assign zero = ZR & (ra == '0);
    assign rd_data[slice_lo(p, DATA_W) +: DATA_W] = (!ready || zero) ? '0 : hit ? wr_merged : mem_q[ra];
  end
  for (genvar r = 0; r < DEPTH; r++) begin : g_out
    assign reg_out[(DEPTH-1-r)*DATA_W +: DATA_W] = (ZR && r == 0) ? '0 : mem_q[r];
  end
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed stimulus with a queued scoreboard checked by a negedge monitor
module tb_regfile_mp;
  localparam int K_RDY = 0, K_RDYNB = 1, K_RD = 2, K_RDNB = 3, K_REG = 4, K_REGNB = 5, K_ALL0 = 6;
  typedef struct {
    int          kind;
    int          idx;
    logic [31:0] exp;
    string       name;
  } item_t;
  item_t sb[$];
  int checks = 0, errors = 0;
  logic          clk = 0, rst = 1, clr_req = 0, wr_en = 0;
  logic          ready, ready_nb;
  logic [9:0]    rd_addr = '0;
  logic [63:0]   rd_data, rd_data_nb;
  logic [4:0]    wr_addr = '0;
  logic [3:0]    wr_be = '0;
  logic [31:0]   wr_data = '0;
  logic [1023:0] reg_out, reg_out_nb;
  always #5 clk = ~clk;
  regfile_mp dut (
    .clk(clk), .rst(rst), .clr_req(clr_req), .ready(ready), .rd_addr(rd_addr), .rd_data(rd_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be), .wr_data(wr_data), .reg_out(reg_out)
  );
  regfile_mp #(.BYPASS(0)) dut_nb (
    .clk(clk), .rst(rst), .clr_req(clr_req), .ready(ready_nb), .rd_addr(rd_addr), .rd_data(rd_data_nb),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be), .wr_data(wr_data), .reg_out(reg_out_nb)
  );
  function automatic logic [31:0] actual(input int kind, input int idx);
    case (kind)
      K_RDY:   return {31'b0, ready};
      K_RDYNB: return {31'b0, ready_nb};
      K_RD:    return rd_data[idx*32 +: 32];
      K_RDNB:  return rd_data_nb[idx*32 +: 32];
      K_REG:   return reg_out[(31-idx)*32 +: 32];
      K_REGNB: return reg_out_nb[(31-idx)*32 +: 32];
      default: return {30'b0, |reg_out_nb, |reg_out};
    endcase
  endfunction
  always @(negedge clk) begin
    while (sb.size() > 0) begin
      item_t it;
      logic [31:0] a;
      it = sb.pop_front();
      a = actual(it.kind, it.idx);
      checks++;
      if (a !== it.exp) begin
        errors++;
        $display("FAIL %s: got %h expected %h", it.name, a, it.exp);
      end
    end
  end
  task automatic expect_v(input int kind, input int idx, input logic [31:0] exp, input string name);
    item_t it;
    it.kind = kind; it.idx = idx; it.exp = exp; it.name = name;
    sb.push_back(it);
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic wr(input logic [4:0] a, input logic [31:0] d, input logic [3:0] be);
    wr_en = 1; wr_addr = a; wr_data = d; wr_be = be;
  endtask
  task automatic ready_window(input string name);
    for (int k = 0; k <= 32; k++) begin
      expect_v(K_RDY, 0, {31'b0, k >= 32}, name);
      expect_v(K_RDYNB, 0, {31'b0, k >= 32}, name);
      tick();
    end
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
  initial begin
    tick();
    expect_v(K_RDY, 0, 32'd0, "ready_in_reset");
    expect_v(K_RD, 0, 32'd0, "rd_in_reset");
    tick(); tick();
    rst = 0;
    ready_window("reset_ready_timing");
    expect_v(K_ALL0, 0, 32'd0, "reg_out_zero");
    for (int a = 0; a < 32; a++) begin
      rd_addr = {5'(a), 5'(a)};
      expect_v(K_RD, 0, 32'd0, "init_read_p0");
      expect_v(K_RD, 1, 32'd0, "init_read_p1");
      tick();
    end
    wr(5, 32'hAABBCCDD, 4'hF);
    tick();
    wr(5, 32'h11223344, 4'b0101);
    rd_addr = {5'd5, 5'd5};
    expect_v(K_RD, 0, 32'hAA22CC44, "be_bypass_p0");
    expect_v(K_RDNB, 0, 32'hAABBCCDD, "be_nobypass_p0");
    tick();
    wr_en = 0;
    expect_v(K_RD, 0, 32'hAA22CC44, "be_read_p0");
    expect_v(K_RD, 1, 32'hAA22CC44, "be_read_p1");
    expect_v(K_RDNB, 1, 32'hAA22CC44, "be_read_nb_p1");
    expect_v(K_REG, 5, 32'hAA22CC44, "be_reg_out");
    tick();
    wr(0, 32'hFFFFFFFF, 4'hF);
    rd_addr = {5'd0, 5'd0};
    expect_v(K_RD, 0, 32'd0, "zero_same_cycle");
    tick();
    wr_en = 0;
    expect_v(K_RD, 0, 32'd0, "zero_after");
    expect_v(K_REG, 0, 32'd0, "zero_reg_out");
    tick();
    wr(7, 32'h12345678, 4'hF);
    tick();
    wr(7, 32'hCAFEF00D, 4'b0011);
    rd_addr = {5'd7, 5'd0};
    expect_v(K_RD, 1, 32'h1234F00D, "bypass_merged");
    expect_v(K_RDNB, 1, 32'h12345678, "nobypass_old");
    tick();
    wr_en = 0;
    expect_v(K_RD, 1, 32'h1234F00D, "bypass_next");
    expect_v(K_RDNB, 1, 32'h1234F00D, "nobypass_next");
    tick();
    clr_req = 1;
    wr(3, 32'h55, 4'hF);
    rd_addr = {5'd0, 5'd3};
    expect_v(K_RDY, 0, 32'd1, "clr_ready_before");
    expect_v(K_RD, 0, 32'h55, "clr_cycle_bypass");
    tick();
    clr_req = 0; wr_en = 0;
    expect_v(K_RDY, 0, 32'd0, "clr_ready_fall");
    expect_v(K_REG, 3, 32'h55, "clr_write_committed");
    expect_v(K_RD, 0, 32'd0, "clr_read_zero");
    tick();
    wr(4, 32'h66, 4'hF);
    tick();
    wr_en = 0;
    expect_v(K_REG, 4, 32'd0, "clr_write_dropped");
    for (int k = 3; k <= 33; k++) begin
      expect_v(K_RDY, 0, {31'b0, k == 33}, "clr_ready_timing");
      if (k < 33) tick();
    end
    rd_addr = {5'd4, 5'd3};
    expect_v(K_REG, 3, 32'd0, "clr_r3_wiped");
    expect_v(K_REG, 4, 32'd0, "clr_r4_zero");
    expect_v(K_RD, 0, 32'd0, "clr_rd_r3");
    expect_v(K_RD, 1, 32'd0, "clr_rd_r4");
    expect_v(K_REGNB, 7, 32'd0, "clr_nb_r7_wiped");
    tick();
    clr_req = 1;
    tick();
    clr_req = 0;
    repeat (17) tick();
    rst = 1;
    tick();
    rst = 0;
    ready_window("midsweep_restart");
    tick();
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
